// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the program sequencer: widths, instruction field layout,
// state and mode encodings.
package instr_sequencer_pkg;

    localparam int unsigned INSTR_W       = 16;
    localparam int unsigned NIB_W         = 4;
    localparam int unsigned DEF_DEPTH     = 8;
    localparam int unsigned DEF_PC_W      = 3;
    localparam int unsigned DEF_EXEC_WAIT = 2;

    // Instruction field positions as seen by the datapath
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD1_MSB = 11;
    localparam int unsigned RD1_LSB = 8;
    localparam int unsigned RD2_MSB = 7;
    localparam int unsigned RD2_LSB = 4;
    localparam int unsigned WR_MSB  = 3;
    localparam int unsigned WR_LSB  = 0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_PAUSE = 3'd4;
    localparam logic [2:0] ST_HALT  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_EXEC  = ST_EXEC,
        S_WRITE = ST_WRITE,
        S_PAUSE = ST_PAUSE,
        S_HALT  = ST_HALT
    } state_e;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_STEP = 1'b1
    } mode_e;

endpackage

// File: rtl/instr_sequencer_mem.sv
// Program store: DEPTH x DATA_W words, synchronous write, asynchronous read.
module instr_mem #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: assembles 16-bit words from switch nibbles into a small program,
// then issues them to the datapath with a settle delay and a one-cycle write strobe.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned PC_W      = DEF_PC_W,
    parameter int unsigned EXEC_WAIT = DEF_EXEC_WAIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_nibble,
    input  logic [3:0]         nibble,
    input  logic               run,
    input  logic               step,
    input  logic               clear,
    input  logic               alu_overflow,
    output logic [15:0]        instruction,
    output logic               write_pulse,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W:0]      prog_len,
    output logic [1:0]         nib_cnt,
    output logic               busy,
    output logic               halted,
    output logic               done
);

    localparam int unsigned WAIT_W = $clog2(EXEC_WAIT + 1);
    localparam int unsigned ASM_W  = INSTR_W - NIB_W;

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [PC_W:0]        prog_len_q, prog_len_d;
    logic [1:0]           nib_cnt_q, nib_cnt_d;
    logic [ASM_W-1:0]     asm_q, asm_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 write_pulse_q, write_pulse_d;
    logic                 busy_q, busy_d;
    logic                 halted_q, halted_d;
    logic                 done_q, done_d;

    logic                 mem_we;
    logic [PC_W-1:0]      mem_waddr;
    logic [INSTR_W-1:0]   mem_wdata;
    logic [INSTR_W-1:0]   mem_rdata;

    logic                 prog_full;
    logic                 last_instr;

    assign prog_full  = (prog_len_q == (PC_W+1)'(DEPTH));
    assign last_instr = ({1'b0, pc_q} == (prog_len_q - (PC_W+1)'(1)));

    instr_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PC_W),
        .DATA_W (INSTR_W)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .raddr  (pc_q),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mode_q        <= MODE_RUN;
            pc_q          <= '0;
            prog_len_q    <= '0;
            nib_cnt_q     <= '0;
            asm_q         <= '0;
            wait_q        <= '0;
            instr_q       <= '0;
            write_pulse_q <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            pc_q          <= pc_d;
            prog_len_q    <= prog_len_d;
            nib_cnt_q     <= nib_cnt_d;
            asm_q         <= asm_d;
            wait_q        <= wait_d;
            instr_q       <= instr_d;
            write_pulse_q <= write_pulse_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        pc_d          = pc_q;
        prog_len_d    = prog_len_q;
        nib_cnt_d     = nib_cnt_q;
        asm_d         = asm_q;
        wait_d        = wait_q;
        instr_d       = instr_q;
        write_pulse_d = 1'b0;
        halted_d      = halted_q;
        done_d        = done_q;
        mem_we        = 1'b0;
        mem_waddr     = prog_len_q[PC_W-1:0];
        mem_wdata     = {asm_q, nibble};

        unique case (state_q)
            S_IDLE: begin
                // The fourth nibble goes straight into memory alongside the three held ones
                if (load_nibble && !prog_full) begin
                    asm_d = {asm_q[ASM_W-NIB_W-1:0], nibble};
                    if (nib_cnt_q == 2'd3) begin
                        mem_we     = 1'b1;
                        prog_len_d = prog_len_q + (PC_W+1)'(1);
                        nib_cnt_d  = 2'd0;
                    end else begin
                        nib_cnt_d  = nib_cnt_q + 2'd1;
                    end
                end
                if (clear) begin
                    done_d = 1'b0;
                end
                if ((run || step) && (prog_len_q != '0)) begin
                    state_d = S_FETCH;
                    mode_d  = run ? MODE_RUN : MODE_STEP;
                    pc_d    = '0;
                    done_d  = 1'b0;
                end
            end
            S_FETCH: begin
                instr_d = mem_rdata;
                wait_d  = WAIT_W'(EXEC_WAIT);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (wait_q <= WAIT_W'(1)) begin
                    state_d       = S_WRITE;
                    write_pulse_d = 1'b1;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_WRITE: begin
                if (alu_overflow) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (last_instr) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    pc_d    = '0;
                end else begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = (mode_q == MODE_RUN) ? S_FETCH : S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (run || step) begin
                    state_d = S_FETCH;
                    if (run) begin
                        mode_d = MODE_RUN;
                    end
                end else if (clear) begin
                    state_d = S_IDLE;
                    pc_d    = '0;
                end
            end
            S_HALT: begin
                if (clear) begin
                    state_d  = S_IDLE;
                    pc_d     = '0;
                    halted_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_WRITE);
    end

    assign instruction = instr_q;
    assign write_pulse = write_pulse_q;
    assign pc          = pc_q;
    assign prog_len    = prog_len_q;
    assign nib_cnt     = nib_cnt_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: expected issued words are queued when a
// program is started and matched against each write strobe.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_nibble;
    logic [3:0]  nibble;
    logic        run;
    logic        step;
    logic        clear;
    logic        alu_overflow;
    logic [15:0] instruction;
    logic        write_pulse;
    logic [2:0]  pc;
    logic [3:0]  prog_len;
    logic [1:0]  nib_cnt;
    logic        busy;
    logic        halted;
    logic        done;

    typedef struct packed {
        logic [15:0] instr;
        logic [2:0]  pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulse_cnt = 0;
    int   base_cnt;
    int   lat;

    always #5 clk = ~clk;

    instr_sequencer #(
        .DEPTH     (8),
        .PC_W      (3),
        .EXEC_WAIT (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_nibble  (load_nibble),
        .nibble       (nibble),
        .run          (run),
        .step         (step),
        .clear        (clear),
        .alu_overflow (alu_overflow),
        .instruction  (instruction),
        .write_pulse  (write_pulse),
        .pc           (pc),
        .prog_len     (prog_len),
        .nib_cnt      (nib_cnt),
        .busy         (busy),
        .halted       (halted),
        .done         (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Every write strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (write_pulse === 1'b1) begin
            pulse_cnt++;
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", 32'(write_pulse), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("wr_instr", 32'(instruction), 32'(mon_e.instr));
                check_eq("wr_pc", 32'(pc), 32'(mon_e.pc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic load_word(input logic [15:0] w);
        for (int i = 0; i < 4; i++) begin
            load_nibble = 1'b1;
            nibble      = w[15-4*i -: 4];
            tick();
        end
        load_nibble = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] w, input logic [2:0] p);
        exp_t e;
        e.instr = w;
        e.pc    = p;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int i = 0;
        while (done !== 1'b1 && i < limit) begin
            tick();
            i++;
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_pulse(input string tag, input int limit, output int n);
        n = 0;
        while (write_pulse !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(write_pulse), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_instr"},    32'(instruction), 32'd0);
        check_eq({tag, "_wp"},       32'(write_pulse), 32'd0);
        check_eq({tag, "_pc"},       32'(pc),          32'd0);
        check_eq({tag, "_prog_len"}, 32'(prog_len),    32'd0);
        check_eq({tag, "_nib_cnt"},  32'(nib_cnt),     32'd0);
        check_eq({tag, "_busy"},     32'(busy),        32'd0);
        check_eq({tag, "_halted"},   32'(halted),      32'd0);
        check_eq({tag, "_done"},     32'(done),        32'd0);
    endtask

    initial begin
        rst = 1'b1; load_nibble = 1'b0; nibble = 4'h0;
        run = 1'b0; step = 1'b0; clear = 1'b0; alu_overflow = 1'b0;

        // 1: reset values, nibble assembly, single-word program
        do_reset();
        check_reset_outputs("rst");
        for (int i = 1; i <= 3; i++) begin
            load_nibble = 1'b1;
            nibble      = 4'(i);
            tick();
        end
        load_nibble = 1'b0;
        check_eq("t1_nib_cnt3", 32'(nib_cnt), 32'd3);
        check_eq("t1_len0", 32'(prog_len), 32'd0);
        load_nibble = 1'b1; nibble = 4'h4; tick(); load_nibble = 1'b0;
        check_eq("t1_len1", 32'(prog_len), 32'd1);
        check_eq("t1_nib_cnt0", 32'(nib_cnt), 32'd0);
        push_exp(16'h1234, 3'd0);
        pulse_run();
        wait_done("t1_done", 20);

        // 2: two-word run with latency checks
        do_reset();
        load_word(16'h1234);
        load_word(16'h5678);
        check_eq("t2_len", 32'(prog_len), 32'd2);
        base_cnt = pulse_cnt;
        push_exp(16'h1234, 3'd0);
        push_exp(16'h5678, 3'd1);
        pulse_run();
        check_eq("t2_busy_fetch", 32'(busy), 32'd1);
        check_eq("t2_instr_pre", 32'(instruction), 32'd0);
        tick();
        check_eq("t2_instr_fetch", 32'(instruction), 32'h1234);
        wait_pulse("t2_pulse", 20, lat);
        check_eq("t2_pulse_lat", 32'(lat), 32'd2);
        tick();
        check_eq("t2_pulse_width", 32'(write_pulse), 32'd0);
        wait_done("t2_done", 20);
        check_eq("t2_pc", 32'(pc), 32'd0);
        check_eq("t2_busy_end", 32'(busy), 32'd0);
        check_eq("t2_pulses", 32'(pulse_cnt - base_cnt), 32'd2);
        check_eq("t2_instr_hold", 32'(instruction), 32'h5678);

        // 3: single stepping through the same program
        base_cnt = pulse_cnt;
        push_exp(16'h1234, 3'd0);
        pulse_step();
        check_eq("t3_done_clr", 32'(done), 32'd0);
        wait_pulse("t3_pulse1", 20, lat);
        tick();
        for (int i = 0; i < 4; i++) tick();
        check_eq("t3_pause_busy", 32'(busy), 32'd0);
        check_eq("t3_pause_pc", 32'(pc), 32'd1);
        check_eq("t3_pause_pulses", 32'(pulse_cnt - base_cnt), 32'd1);
        push_exp(16'h5678, 3'd1);
        pulse_step();
        wait_done("t3_done", 20);
        check_eq("t3_pulses", 32'(pulse_cnt - base_cnt), 32'd2);

        // 4: overflow on first write halts; only clear leaves HALT; program retained
        base_cnt = pulse_cnt;
        push_exp(16'h1234, 3'd0);
        pulse_run();
        wait_pulse("t4_pulse", 20, lat);
        alu_overflow = 1'b1;
        tick();
        alu_overflow = 1'b0;
        check_eq("t4_halted", 32'(halted), 32'd1);
        check_eq("t4_pc", 32'(pc), 32'd0);
        check_eq("t4_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check_eq("t4_no_fetch", 32'(instruction), 32'h1234);
        check_eq("t4_pulses", 32'(pulse_cnt - base_cnt), 32'd1);
        pulse_run();
        tick();
        check_eq("t4_run_ignored", 32'(halted), 32'd1);
        check_eq("t4_run_ign_busy", 32'(busy), 32'd0);
        pulse_clear();
        check_eq("t4_clear_halted", 32'(halted), 32'd0);
        check_eq("t4_clear_pc", 32'(pc), 32'd0);
        push_exp(16'h1234, 3'd0);
        push_exp(16'h5678, 3'd1);
        pulse_run();
        wait_done("t4_rerun_done", 20);
        pulse_clear();
        check_eq("t4_clear_done", 32'(done), 32'd0);

        // 5: overfill ignored; run and step together behave as run
        do_reset();
        for (int i = 0; i < 9; i++) load_word(16'hA000 + 16'(i));
        check_eq("t5_len", 32'(prog_len), 32'd8);
        check_eq("t5_nib_cnt", 32'(nib_cnt), 32'd0);
        base_cnt = pulse_cnt;
        for (int i = 0; i < 8; i++) push_exp(16'hA000 + 16'(i), 3'(i));
        run = 1'b1; step = 1'b1;
        tick();
        run = 1'b0; step = 1'b0;
        wait_done("t5_done", 60);
        check_eq("t5_pulses", 32'(pulse_cnt - base_cnt), 32'd8);
        check_eq("t5_last", 32'(instruction), 32'hA007);

        // 6: reset mid-execution erases program
        do_reset();
        load_word(16'h1234);
        load_word(16'h5678);
        push_exp(16'h1234, 3'd0);
        pulse_run();
        tick();
        tick();
        check_eq("t6_busy_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("t6");
        rst = 1'b0;
        sb.delete();
        base_cnt = pulse_cnt;
        pulse_run();
        for (int i = 0; i < 6; i++) tick();
        check_eq("t6_run_ign_busy", 32'(busy), 32'd0);
        check_eq("t6_run_ign_pulses", 32'(pulse_cnt - base_cnt), 32'd0);
        check_eq("t6_run_ign_instr", 32'(instruction), 32'd0);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
